// File: rtl/doorlock_supervisor_pkg.sv
// Shared state encoding, digit width and helpers for the door-lock session controller.
package doorlock_supervisor_pkg;

    localparam int unsigned DigitW = 2;
    localparam int unsigned NumBtn = 3;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StEntry = 3'd1,
        StOk    = 3'd2,
        StFail  = 3'd3,
        StLock  = 3'd4,
        StProg  = 3'd5
    } state_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/doorlock_supervisor_btn_edge_det.sv
// Two-flop synchroniser/edge detector: rise is high for one cycle after din is first sampled high.
module doorlock_supervisor_btn_edge_det (
    input  logic clk,
    input  logic n_rst,
    input  logic din,
    output logic level,
    output logic rise
);

    logic d1_q, d2_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            d1_q <= 1'b0;
            d2_q <= 1'b0;
        end else begin
            d1_q <= din;
            d2_q <= d1_q;
        end
    end

    assign level = d1_q;
    assign rise  = d1_q & ~d2_q;

endmodule

// File: rtl/doorlock_supervisor.sv
// Keypad door-lock session controller: digit entry, verdict display and failure lockout.
// Define DOORLOCK_PROG_EN to add a prog input and a reprogrammable code register.
module doorlock_supervisor
    import doorlock_supervisor_pkg::*;
#(
    parameter int unsigned                CODE_LEN = 3,
    parameter logic [DigitW*CODE_LEN-1:0] CODE     = 6'b01_00_10,
    parameter int unsigned                MAX_FAIL = 3,
    parameter int unsigned                SHOW_CYC = 4,
    parameter int unsigned                ENTRY_TO = 16,
    parameter int unsigned                LOCK_CYC = 32
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          start,
    input  logic                          bt_0,
    input  logic                          bt_1,
    input  logic                          bt_2,
`ifdef DOORLOCK_PROG_EN
    input  logic                          prog,
`endif
    output logic [CODE_LEN-1:0]           led_prog,
    output logic                          led_ok,
    output logic                          led_fail,
    output logic                          led_lock,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt,
    output logic                          busy
);

    localparam int unsigned FailW    = $clog2(MAX_FAIL + 1);
    localparam int unsigned IdxW     = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int unsigned TimerMax = max3(ENTRY_TO, SHOW_CYC, LOCK_CYC);
    localparam int unsigned TimerW   = (TimerMax > 1) ? $clog2(TimerMax) : 1;

    localparam logic [TimerW-1:0] EntryLoad = TimerW'(ENTRY_TO - 1);
    localparam logic [TimerW-1:0] ShowLoad  = TimerW'(SHOW_CYC - 1);
    localparam logic [TimerW-1:0] LockLoad  = TimerW'(LOCK_CYC - 1);
    localparam logic [IdxW-1:0]   LastIdx   = IdxW'(CODE_LEN - 1);
    localparam logic [FailW-1:0]  FailMax   = FailW'(MAX_FAIL);

    state_t                     state_q, state_d;
    logic [IdxW-1:0]            idx_q, idx_d;
    logic                       mis_q, mis_d;
    logic [CODE_LEN-1:0]        prog_q, prog_d;
    logic [TimerW-1:0]          timer_q, timer_d;
    logic [FailW-1:0]           fail_q, fail_d, fail_sat;
    logic [DigitW*CODE_LEN-1:0] code_cur;
`ifdef DOORLOCK_PROG_EN
    logic [DigitW*CODE_LEN-1:0] code_q, code_d, buf_q, buf_d;
    logic                       from_prog_q, from_prog_d;
`endif

    logic [NumBtn-1:0] bt, press, unused_bt_lvl;
    logic              start_lvl, start_rise;
    logic              digit_evt, multi, digit_mis;
    logic [DigitW-1:0] digit;

    assign bt = {bt_2, bt_1, bt_0};

    for (genvar i = 0; i < NumBtn; i++) begin : g_btn
        doorlock_supervisor_btn_edge_det u_btn_det (
            .clk   (clk),
            .n_rst (n_rst),
            .din   (bt[i]),
            .level (unused_bt_lvl[i]),
            .rise  (press[i])
        );
    end

    doorlock_supervisor_btn_edge_det u_start_det (
        .clk   (clk),
        .n_rst (n_rst),
        .din   (start),
        .level (start_lvl),
        .rise  (start_rise)
    );

`ifdef DOORLOCK_PROG_EN
    assign code_cur = code_q;
`else
    assign code_cur = CODE;
`endif

    // Simultaneous presses collapse into one digit that can never match.
    assign digit_evt = |press;
    assign multi     = (press[0] & press[1]) | (press[0] & press[2]) | (press[1] & press[2]);
    assign digit     = press[2] ? 2'd2 : (press[1] ? 2'd1 : 2'd0);
    assign digit_mis = multi | (digit != code_cur[32'(idx_q) * DigitW +: DigitW]);
    assign fail_sat  = (fail_q == FailMax) ? fail_q : fail_q + 1'b1;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            mis_q       <= 1'b0;
            prog_q      <= '0;
            timer_q     <= '0;
            fail_q      <= '0;
`ifdef DOORLOCK_PROG_EN
            code_q      <= CODE;
            buf_q       <= '0;
            from_prog_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mis_q       <= mis_d;
            prog_q      <= prog_d;
            timer_q     <= timer_d;
            fail_q      <= fail_d;
`ifdef DOORLOCK_PROG_EN
            code_q      <= code_d;
            buf_q       <= buf_d;
            from_prog_q <= from_prog_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mis_d   = mis_q;
        prog_d  = prog_q;
        timer_d = timer_q;
        fail_d  = fail_q;
`ifdef DOORLOCK_PROG_EN
        code_d      = code_q;
        buf_d       = buf_q;
        from_prog_d = from_prog_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_rise) begin
                    state_d = StEntry;
                    idx_d   = '0;
                    mis_d   = 1'b0;
                    prog_d  = '0;
                    timer_d = EntryLoad;
                end
            end
            StEntry: begin
                if (!start_lvl) begin
                    state_d = StIdle;
                    prog_d  = '0;
                end else if (digit_evt) begin
                    prog_d[idx_q] = 1'b1;
                    mis_d         = mis_q | digit_mis;
                    idx_d         = idx_q + 1'b1;
                    timer_d       = EntryLoad;
                    if (idx_q == LastIdx) begin
                        timer_d = ShowLoad;
                        if (mis_d) begin
                            state_d = StFail;
                            fail_d  = fail_sat;
                        end else begin
                            state_d = StOk;
                            fail_d  = '0;
                        end
                    end
                end else if (timer_q == '0) begin
                    state_d = StFail;
                    timer_d = ShowLoad;
                    fail_d  = fail_sat;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StOk: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end
`ifdef DOORLOCK_PROG_EN
                else if (prog && !from_prog_q) begin
                    state_d = StProg;
                    idx_d   = '0;
                    prog_d  = '0;
                    timer_d = EntryLoad;
                end
`endif
                else begin
                    state_d = StIdle;
                    prog_d  = '0;
`ifdef DOORLOCK_PROG_EN
                    from_prog_d = 1'b0;
`endif
                end
            end
            StFail: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else if (fail_q == FailMax) begin
                    state_d = StLock;
                    timer_d = LockLoad;
                    prog_d  = '0;
                end else begin
                    state_d = StIdle;
                    prog_d  = '0;
                end
            end
            StLock: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else begin
                    state_d = StIdle;
                    fail_d  = '0;
                end
            end
`ifdef DOORLOCK_PROG_EN
            StProg: begin
                if (!start_lvl) begin
                    state_d = StIdle;
                    prog_d  = '0;
                end else if (multi) begin
                    state_d = StFail;
                    timer_d = ShowLoad;
                end else if (digit_evt) begin
                    prog_d[idx_q]                           = 1'b1;
                    buf_d[32'(idx_q) * DigitW +: DigitW] = digit;
                    idx_d                                   = idx_q + 1'b1;
                    timer_d                                 = EntryLoad;
                    if (idx_q == LastIdx) begin
                        code_d      = buf_d;
                        from_prog_d = 1'b1;
                        state_d     = StOk;
                        timer_d     = ShowLoad;
                        fail_d      = '0;
                    end
                end else if (timer_q == '0) begin
                    state_d = StFail;
                    timer_d = ShowLoad;
                    fail_d  = fail_sat;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        led_prog = prog_q;
        led_ok   = (state_q == StOk);
        led_fail = (state_q == StFail);
        led_lock = (state_q == StLock);
        fail_cnt = fail_q;
        busy     = (state_q != StIdle);
    end

endmodule
